subneg_core_p: RTL and testbench
================================

SUBNEG_CORE_P -- requirements
Module: subneg_core_p

Interface
REQ-001 Parameter DATA_W, default 8, data word width (>=4).
REQ-002 Parameter ADDR_W, default 5, address width; DATA_W >= ADDR_W.
REQ-003 Parameter DEPTH, default 32, memory words, DEPTH <= 2**ADDR_W.
REQ-004 Parameter LEQ_MODE, default 1: 1 = branch when signed result <= 0; 0 = branch when mem[A] > mem[B] unsigned.
REQ-005 clk  in  1  clock.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 run  in  1  level; 1 = free-run execution.
REQ-008 step  in  1  one-cycle pulse; executes one instruction while run=0.
REQ-009 load_en  in  1  program-load write strobe.
REQ-010 load_addr  in  ADDR_W  program-load address.
REQ-011 load_data  in  DATA_W  program-load data.
REQ-012 in_data  in  DATA_W  value returned by reads of IN_ADDR = DEPTH-2.
REQ-013 out_data  out  DATA_W  value written to OUT_ADDR = DEPTH-1.
REQ-014 out_valid  out  1  out_data pending.
REQ-015 out_ready  in  1  consumer accepts out_data.
REQ-016 pc  out  ADDR_W  current program counter.
REQ-017 busy  out  1  high in FETCH, READ, EXEC, WAIT_OUT.
REQ-018 halted  out  1  core in HALT.

Function
REQ-019 States: IDLE, FETCH, READ, EXEC, WAIT_OUT, HALT.
REQ-020 IDLE -> FETCH when run=1 or step=1; otherwise stay in IDLE.
REQ-021 FETCH: latch A=mem[pc], B=mem[pc+1], C=mem[pc+2], low ADDR_W bits, indices mod DEPTH.
REQ-022 READ: latch valA=rd(A), valB=rd(B); rd(IN_ADDR)=in_data, rd(OUT_ADDR)=0, rd(addr>=DEPTH)=0.
REQ-023 EXEC: res = valB - valA mod 2**DATA_W; B>=DEPTH: write dropped; B=OUT_ADDR: routed to output; else mem[B]<=res.
REQ-024 Branch taken: pc<=C; not taken: pc<=(pc+3) mod DEPTH.
REQ-025 One instruction = 3 cycles (FETCH, READ, EXEC) absent stalls.
REQ-026 Output write with out_valid=0: out_data<=res, out_valid<=1, instruction completes in EXEC.
REQ-027 Output write with out_valid=1 and out_ready=0: enter WAIT_OUT, pc frozen; retry each cycle; complete on the cycle out_ready=1.
REQ-028 out_valid clears on out_valid&out_ready unless a new output write lands the same cycle (then stays 1 with new data).
REQ-029 Halt: taken branch with C == current pc -> pc<=C, state HALT; HALT sticky until reset.
REQ-030 After an instruction completes: run=1 -> FETCH; run=0 -> IDLE (single-step).
REQ-031 load_en honoured only in IDLE or HALT; ignored otherwise; load to address >=DEPTH dropped.
REQ-032 step ignored unless state is IDLE; run and step both high behaves as run.

Reset
REQ-033 On reset: state IDLE, pc=0, out_data=0, out_valid=0, busy=0, halted=0, latches A/B/C/valA/valB=0.
REQ-034 Memory contents not cleared by reset; reset mid-instruction abandons it with no memory write.

Structure
REQ-035 Shared package subneg_pkg: state enum, IN_ADDR/OUT_ADDR offset constants.
REQ-036 One sub-module subneg_mem: DEPTH x DATA_W register array, 3 async read ports, 1 sync write port; core muxes load port vs EXEC write.

Verification (DATA_W=8, ADDR_W=5, DEPTH=32)
REQ-037 Reset held 2 cycles with run=1 -> all outputs 0, state IDLE, pc=0.
REQ-038 Load mem[0..5]=10,11,3,12,12,3; mem[10]=2, mem[11]=5, mem[12]=0; run=1 -> mem[11]=3 after 3 cycles, pc=3; halted=1 3 cycles later (LEQ_MODE=1).
REQ-039 Same program, LEQ_MODE=0 -> no halt at pc=3, pc advances to 6.
REQ-040 Instruction (13,31,0), mem[13]=0xF9, out_ready=0 -> out_data=7, out_valid=1; next output write stalls in WAIT_OUT, pc frozen 5 cycles; out_ready=1 -> transfer, execution resumes.
REQ-041 run=0, step pulses -> exactly one instruction per pulse, pc += 3 each, busy low between pulses.
REQ-042 Reset asserted during EXEC of a write to mem[11] -> mem[11] unchanged, pc=0.

Source files
------------

// File: rtl/subneg_pkg.sv
// Shared definitions for the subneg core: sequencer states and the offsets
// (from the top of memory) of the memory-mapped input and output words.
package subneg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_READ     = 3'd2,
    ST_EXEC     = 3'd3,
    ST_WAIT_OUT = 3'd4,
    ST_HALT     = 3'd5
  } state_t;

  localparam int IN_OFFSET  = 2;
  localparam int OUT_OFFSET = 1;

endpackage

// File: rtl/subneg_mem.sv
// DEPTH x DATA_W register-file memory: three asynchronous read ports and one
// synchronous write port; out-of-range reads return zero, out-of-range writes drop.
module subneg_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] rd_addr0,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data0,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  function automatic logic [DATA_W-1:0] rd_word(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] word_v;
    if (32'(addr) < 32'(DEPTH)) begin
      word_v = mem_r[addr];
    end else begin
      word_v = {DATA_W{1'b0}};
    end
    return word_v;
  endfunction

  // Asynchronous read ports.
  always_comb begin
    rd_data0 = rd_word(rd_addr0);
    rd_data1 = rd_word(rd_addr1);
    rd_data2 = rd_word(rd_addr2);
  end

  // Synchronous write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < 32'(DEPTH))) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/subneg_core_p.sv
// Subtract-and-branch core: FETCH/READ/EXEC sequencer around subneg_mem with a
// one-entry output holding register and a sticky HALT on a self-branch.
module subneg_core_p
  import subneg_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int LEQ_MODE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] IN_ADDR  = ADDR_W'(DEPTH - IN_OFFSET);
  localparam logic [ADDR_W-1:0] OUT_ADDR = ADDR_W'(DEPTH - OUT_OFFSET);

  state_t            state_r, state_nxt_s;
  logic [ADDR_W-1:0] pc_r, pc_nxt_s, a_r, b_r, c_r;
  logic [DATA_W-1:0] val_a_r, val_b_r, out_data_r;
  logic              out_valid_r, busy_r, halted_r;
  logic [ADDR_W-1:0] rd_addr0_s, rd_addr1_s, rd_addr2_s;
  logic [DATA_W-1:0] rd_data0_s, rd_data1_s, rd_data2_s;
  logic [DATA_W-1:0] res_s;
  logic              taken_s, halt_s, is_out_s, b_in_range_s;
  logic [ADDR_W-1:0] pc_seq_s, pc_target_s;
  logic              mem_wr_en_s;
  logic [ADDR_W-1:0] mem_wr_addr_s;
  logic [DATA_W-1:0] mem_wr_data_s;
  logic              out_load_s, complete_s;

  function automatic logic [ADDR_W-1:0] wrap_add(input logic [ADDR_W-1:0] base,
                                                 input int unsigned inc);
    int unsigned sum_v;
    sum_v = (32'(base) + inc) % 32'(DEPTH);
    return sum_v[ADDR_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] operand(input logic [ADDR_W-1:0] addr,
                                                input logic [DATA_W-1:0] mem_word,
                                                input logic [DATA_W-1:0] in_word);
    logic [DATA_W-1:0] val_v;
    if (addr == IN_ADDR) begin
      val_v = in_word;
    end else if (addr == OUT_ADDR) begin
      val_v = {DATA_W{1'b0}};
    end else begin
      val_v = mem_word;
    end
    return val_v;
  endfunction

  subneg_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_mem (
    .clk      (clk),
    .rd_addr0 (rd_addr0_s),
    .rd_addr1 (rd_addr1_s),
    .rd_addr2 (rd_addr2_s),
    .rd_data0 (rd_data0_s),
    .rd_data1 (rd_data1_s),
    .rd_data2 (rd_data2_s),
    .wr_en    (mem_wr_en_s & ~reset),
    .wr_addr  (mem_wr_addr_s),
    .wr_data  (mem_wr_data_s)
  );

  // Read ports serve the instruction words in FETCH and the operands in READ.
  always_comb begin
    rd_addr2_s = wrap_add(pc_r, 32'd2);
    if (state_r == ST_READ) begin
      rd_addr0_s = a_r;
      rd_addr1_s = b_r;
    end else begin
      rd_addr0_s = pc_r;
      rd_addr1_s = wrap_add(pc_r, 32'd1);
    end
  end

  // Subtract, branch decision and destination decode from the latched operands.
  always_comb begin
    res_s = val_b_r - val_a_r;
    if (LEQ_MODE != 0) begin
      taken_s = res_s[DATA_W-1] | (res_s == {DATA_W{1'b0}});
    end else begin
      taken_s = (val_a_r > val_b_r);
    end
    pc_seq_s = wrap_add(pc_r, 32'd3);
    if (taken_s) begin
      pc_target_s = c_r;
    end else begin
      pc_target_s = pc_seq_s;
    end
    halt_s       = taken_s & (c_r == pc_r);
    is_out_s     = (b_r == OUT_ADDR);
    b_in_range_s = (32'(b_r) < 32'(DEPTH));
  end

  // Next-state, memory write mux (load port vs EXEC result) and completion.
  always_comb begin
    state_nxt_s   = state_r;
    pc_nxt_s      = pc_r;
    mem_wr_en_s   = 1'b0;
    mem_wr_addr_s = load_addr;
    mem_wr_data_s = load_data;
    out_load_s    = 1'b0;
    complete_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        mem_wr_en_s = load_en;
        if (run || step) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH: state_nxt_s = ST_READ;
      ST_READ:  state_nxt_s = ST_EXEC;
      ST_EXEC: begin
        if (is_out_s) begin
          // The holding register frees this cycle if it is empty or being drained.
          if (!out_valid_r || out_ready) begin
            out_load_s = 1'b1;
            complete_s = 1'b1;
          end else begin
            state_nxt_s = ST_WAIT_OUT;
          end
        end else begin
          mem_wr_en_s   = b_in_range_s;
          mem_wr_addr_s = b_r;
          mem_wr_data_s = res_s;
          complete_s    = 1'b1;
        end
      end
      ST_WAIT_OUT: begin
        if (out_ready) begin
          out_load_s = 1'b1;
          complete_s = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT_OUT;
        end
      end
      ST_HALT: begin
        mem_wr_en_s = load_en;
        state_nxt_s = ST_HALT;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
    if (complete_s) begin
      pc_nxt_s = pc_target_s;
      if (halt_s) begin
        state_nxt_s = ST_HALT;
      end else if (run) begin
        state_nxt_s = ST_FETCH;
      end else begin
        state_nxt_s = ST_IDLE;
      end
    end else begin
      pc_nxt_s = pc_r;
    end
  end

  // Sequencer state, pc, operand latches and registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      pc_r     <= {ADDR_W{1'b0}};
      a_r      <= {ADDR_W{1'b0}};
      b_r      <= {ADDR_W{1'b0}};
      c_r      <= {ADDR_W{1'b0}};
      val_a_r  <= {DATA_W{1'b0}};
      val_b_r  <= {DATA_W{1'b0}};
      busy_r   <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      pc_r     <= pc_nxt_s;
      busy_r   <= (state_nxt_s == ST_FETCH) || (state_nxt_s == ST_READ) ||
                  (state_nxt_s == ST_EXEC)  || (state_nxt_s == ST_WAIT_OUT);
      halted_r <= (state_nxt_s == ST_HALT);
      if (state_r == ST_FETCH) begin
        a_r <= rd_data0_s[ADDR_W-1:0];
        b_r <= rd_data1_s[ADDR_W-1:0];
        c_r <= rd_data2_s[ADDR_W-1:0];
      end
      if (state_r == ST_READ) begin
        val_a_r <= operand(a_r, rd_data0_s, in_data);
        val_b_r <= operand(b_r, rd_data1_s, in_data);
      end
    end
  end

  // Output holding register: a new write wins over a same-cycle drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_r  <= {DATA_W{1'b0}};
      out_valid_r <= 1'b0;
    end else if (out_load_s) begin
      out_data_r  <= res_s;
      out_valid_r <= 1'b1;
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign pc        = pc_r;
  assign busy      = busy_r;
  assign halted    = halted_r;

endmodule

// File: tb/tb_subneg_core_p.sv
// Bench for subneg_core_p: directed program checks plus random single-stepped
// programs against an instruction-level model, with an output scoreboard.
module tb_subneg_core_p;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int D  = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          run1 = 1'b0, run0 = 1'b0, step1 = 1'b0, step0 = 1'b0;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [DW-1:0] load_data = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data1, out_data0;
  logic          out_valid1, out_valid0, busy1, busy0, halted1, halted0;
  logic [AW-1:0] pc1, pc0;

  int            vec_cnt = 0;
  int            miscompares = 0;
  logic [DW-1:0] exp_q1[$];
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] ref_mem[2][D];
  int            ref_pc[2];
  bit            ref_halt[2];
  logic [DW-1:0] prog[D];

  always #5 clk = ~clk;

  subneg_core_p #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D), .LEQ_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .run(run1), .step(step1), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .in_data(in_data),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
    .pc(pc1), .busy(busy1), .halted(halted1));

  subneg_core_p #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D), .LEQ_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .run(run0), .step(step0), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .in_data(in_data),
    .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready),
    .pc(pc0), .busy(busy0), .halted(halted0));

  task automatic chk(input string name, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < D; i++) begin
      load_en   = 1'b1;
      load_addr = AW'(i);
      load_data = prog[i];
      tick();
    end
    load_en = 1'b0;
  endtask

  // Scoreboard monitors: every accepted output word is compared with the queue head.
  always @(negedge clk) begin
    if (!reset && out_valid1 && out_ready) begin
      if (exp_q1.size() == 0) chk("out1_unexpected", int'(out_data1), -1);
      else chk("out1_data", int'(out_data1), int'(exp_q1.pop_front()));
    end
    if (!reset && out_valid0 && out_ready) begin
      if (exp_q0.size() == 0) chk("out0_unexpected", int'(out_data0), -1);
      else chk("out0_data", int'(out_data0), int'(exp_q0.pop_front()));
    end
  end

  function automatic logic [DW-1:0] ref_rd(input int m, input int addr);
    if (addr == D - 2) return in_data;
    if (addr == D - 1) return 8'd0;
    return ref_mem[m][addr];
  endfunction

  // One instruction of the architectural machine (m=1: branch on result<=0, m=0: A>B).
  task automatic model_step(input int m);
    int            p, a, b, c;
    logic [DW-1:0] va, vb, res;
    bit            taken;
    if (ref_halt[m]) return;
    p  = ref_pc[m];
    a  = int'(ref_mem[m][p]) % D;
    b  = int'(ref_mem[m][(p + 1) % D]) % D;
    c  = int'(ref_mem[m][(p + 2) % D]) % D;
    va = ref_rd(m, a);
    vb = ref_rd(m, b);
    res = vb - va;
    if (b == D - 1) begin
      if (m == 1) exp_q1.push_back(res);
      else exp_q0.push_back(res);
    end else begin
      ref_mem[m][b] = res;
    end
    if (m == 1) taken = ($signed(res) <= 0);
    else taken = (va > vb);
    if (taken) begin
      if (c == p) ref_halt[m] = 1'b1;
      ref_pc[m] = c;
    end else begin
      ref_pc[m] = (p + 3) % D;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset held two cycles with run high.
    reset = 1'b1; run1 = 1'b1; run0 = 1'b1;
    tick(); tick();
    chk("rst_out_data", int'(out_data1), 0);
    chk("rst_out_valid", int'(out_valid1), 0);
    chk("rst_pc", int'(pc1), 0);
    chk("rst_busy", int'(busy1), 0);
    chk("rst_halted", int'(halted1), 0);
    chk("rst_pc_m0", int'(pc0), 0);
    run1 = 1'b0; run0 = 1'b0;
    reset = 1'b0;

    // Halting program: instruction 0 writes 3 to mem[11], instruction 3 self-branches.
    foreach (prog[i]) prog[i] = 8'd0;
    prog[0] = 8'd10; prog[1] = 8'd11; prog[2] = 8'd3;
    prog[3] = 8'd12; prog[4] = 8'd12; prog[5] = 8'd3;
    prog[10] = 8'd2; prog[11] = 8'd5; prog[12] = 8'd0;
    load_prog();
    run1 = 1'b1; run0 = 1'b1;
    n = 0;
    while (!halted1 && n < 40) begin
      tick();
      n++;
      if (n == 4) begin
        chk("leq_pc_after_inst0", int'(pc1), 3);
        chk("leq_mem11", int'(dut1.u_mem.mem_r[11]), 3);
      end
    end
    chk("leq_halt_cycles", n, 7);
    chk("leq_halted", int'(halted1), 1);
    chk("leq_halt_pc", int'(pc1), 3);
    chk("gt_pc", int'(pc0), 6);
    chk("gt_not_halted", int'(halted0), 0);
    chk("gt_mem11", int'(dut0.u_mem.mem_r[11]), 3);
    run1 = 1'b0; run0 = 1'b0;
    step1 = 1'b1; tick(); step1 = 1'b0; tick();
    chk("halt_sticky", int'(halted1), 1);
    chk("halt_sticky_busy", int'(busy1), 0);
    n = 0;
    while (busy0 && n < 20) begin tick(); n++; end

    // Output stall: first output 0-0xF9=7 lands, the second waits in WAIT_OUT.
    do_reset();
    foreach (prog[i]) prog[i] = 8'd0;
    prog[0] = 8'd13; prog[1] = 8'd31; prog[2] = 8'd0;
    prog[3] = 8'd14; prog[4] = 8'd31; prog[5] = 8'd6;
    prog[6] = 8'd15; prog[7] = 8'd15; prog[8] = 8'd6;
    prog[13] = 8'hF9; prog[14] = 8'hFE;
    load_prog();
    out_ready = 1'b0;
    exp_q1.push_back(8'd7);
    exp_q1.push_back(8'd2);
    run1 = 1'b1;
    n = 0;
    while (!out_valid1 && n < 20) begin tick(); n++; end
    chk("out_first_data", int'(out_data1), 7);
    chk("out_first_pc", int'(pc1), 3);
    tick(); tick(); tick();
    for (int k = 0; k < 5; k++) begin
      chk("stall_pc", int'(pc1), 3);
      chk("stall_busy", int'(busy1), 1);
      tick();
    end
    chk("stall_data_held", int'(out_data1), 7);
    out_ready = 1'b1;
    tick();
    chk("resume_pc", int'(pc1), 6);
    chk("resume_data", int'(out_data1), 2);
    chk("resume_valid", int'(out_valid1), 1);
    n = 0;
    while (!halted1 && n < 20) begin tick(); n++; end
    chk("stall_prog_halted", int'(halted1), 1);
    chk("stall_prog_pc", int'(pc1), 6);
    chk("stall_q_empty", exp_q1.size(), 0);
    run1 = 1'b0;

    // Single-step: one instruction per pulse, busy low in between.
    do_reset();
    foreach (prog[i]) prog[i] = 8'd0;
    for (int k = 0; k < 3; k++) begin
      prog[3*k] = 8'd20; prog[3*k+1] = 8'd21; prog[3*k+2] = 8'd0;
    end
    prog[20] = 8'd1; prog[21] = 8'd100;
    load_prog();
    for (int k = 0; k < 3; k++) begin
      step1 = 1'b1; tick(); step1 = 1'b0;
      n = 0;
      while (busy1 && n < 20) begin tick(); n++; end
      chk("step_busy_cycles", n, 3);
      chk("step_pc", int'(pc1), 3 * (k + 1));
      tick(); tick();
      chk("step_idle_busy", int'(busy1), 0);
      chk("step_idle_pc", int'(pc1), 3 * (k + 1));
    end
    chk("step_mem21", int'(dut1.u_mem.mem_r[21]), 97);

    // Reset during EXEC abandons the write to mem[11].
    do_reset();
    foreach (prog[i]) prog[i] = 8'd0;
    prog[0] = 8'd10; prog[1] = 8'd11; prog[2] = 8'd3;
    prog[10] = 8'd2; prog[11] = 8'd5;
    load_prog();
    step1 = 1'b1; tick(); step1 = 1'b0;
    tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst_exec_mem11", int'(dut1.u_mem.mem_r[11]), 5);
    chk("rst_exec_pc", int'(pc1), 0);
    chk("rst_exec_busy", int'(busy1), 0);

    // Random programs, both branch modes stepped in lockstep with the model.
    for (int p = 0; p < 8; p++) begin
      do_reset();
      in_data = DW'($urandom);
      for (int i = 0; i < D; i++) begin
        prog[i] = ($urandom_range(0, 3) == 0) ? 8'd31 : DW'($urandom);
        ref_mem[0][i] = prog[i];
        ref_mem[1][i] = prog[i];
      end
      load_prog();
      ref_pc[0] = 0; ref_pc[1] = 0;
      ref_halt[0] = 1'b0; ref_halt[1] = 1'b0;
      for (int s = 0; s < 12; s++) begin
        model_step(0);
        model_step(1);
        step1 = 1'b1; step0 = 1'b1; tick(); step1 = 1'b0; step0 = 1'b0;
        n = 0;
        while ((busy1 || busy0) && n < 200) begin
          out_ready = 1'($urandom_range(0, 1));
          tick();
          n++;
        end
        if (busy1 || busy0) chk("rnd_step_timeout", n, 0);
        chk("rnd_pc_leq", int'(pc1), ref_pc[1]);
        chk("rnd_halt_leq", int'(halted1), int'(ref_halt[1]));
        chk("rnd_pc_gt", int'(pc0), ref_pc[0]);
        chk("rnd_halt_gt", int'(halted0), int'(ref_halt[0]));
      end
      out_ready = 1'b1;
      tick(); tick();
      chk("rnd_q1_drained", exp_q1.size(), 0);
      chk("rnd_q0_drained", exp_q0.size(), 0);
      exp_q1.delete();
      exp_q0.delete();
      for (int i = 0; i < D; i++) begin
        chk("rnd_mem_leq", int'(dut1.u_mem.mem_r[i]), int'(ref_mem[1][i]));
        chk("rnd_mem_gt", int'(dut0.u_mem.mem_r[i]), int'(ref_mem[0][i]));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
